// File: rtl/apb_pkg.sv
// Shared APB4 widths and the completer state encoding used by the register-file responder.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_STRB_W = 4;
   localparam int unsigned APB_PROT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_strb_merge.sv
// Combinational byte merge: each strobed byte lane takes the new data, others keep the old.
module apb_strb_merge
   import apb_pkg::*;
(
   input  logic [APB_DATA_W-1:0] old_data,
   input  logic [APB_DATA_W-1:0] new_data,
   input  logic [APB_STRB_W-1:0] strb,
   output logic [APB_DATA_W-1:0] merged
);

   always_comb begin
      merged = old_data;
      for (int unsigned b = 0; b < APB_STRB_W; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
      end
   end

endmodule

// File: rtl/apb_regfile_responder.sv
// APB4 completer: 32-bit register file with byte strobes, fixed wait states and SLVERR.
// Register 0 is the read-only ID (id_i); registers 1..NUM_REGS-1 are read/write.
module apb_regfile_responder
   import apb_pkg::*;
#(
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned           NUM_REGS    = 8,
   parameter int unsigned           WAIT_CYCLES = 0,
   parameter logic [APB_DATA_W-1:0] RESET_VALUE = 32'h0000_0000,
   parameter int unsigned           PRIV_WRITE  = 0
) (
   input  logic                         apb_clk_i,
   input  logic                         apb_reset_i,
   input  logic [APB_ADDR_W-1:0]        apb_addr_i,
   input  logic                         apb_sel_i,
   input  logic                         apb_enable_i,
   input  logic                         apb_write_i,
   input  logic [APB_STRB_W-1:0]        apb_strb_i,
   input  logic [APB_PROT_W-1:0]        apb_prot_i,
   input  logic [APB_DATA_W-1:0]        apb_wdata_i,
   output logic                         apb_ready_o,
   output logic [APB_DATA_W-1:0]        apb_rdata_o,
   output logic                         apb_slverr_o,
   input  logic [APB_DATA_W-1:0]        id_i,
   output logic [APB_DATA_W*NUM_REGS-1:0] regs_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);

   localparam int unsigned IDX_W = 6;

   apb_state_e state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  ready_q, ready_d, slverr_q, slverr_d;
   logic [APB_DATA_W-1:0] rdata_q, rdata_d;
   logic [IDX_W-1:0]      idx_q;
   logic                  write_q, err_q;
   logic [APB_STRB_W-1:0] strb_q;
   logic [APB_DATA_W-1:0] wdata_q;
   logic                  latch, commit, enter_done;

   logic [APB_DATA_W-1:0] regs_q [1:NUM_REGS-1];
   logic [APB_DATA_W-1:0] merged [1:NUM_REGS-1];
   logic [NUM_REGS-1:0]   wr_pulse_q;

   logic [APB_ADDR_W-1:0] off;
   logic                  err_in;
   logic [IDX_W-1:0]      idx_in, cur_idx;
   logic                  cur_err, cur_write;
   logic [APB_DATA_W-1:0] rd_val;
   logic                  unused_prot;

   assign unused_prot = ^apb_prot_i[APB_PROT_W-1:1];

   // Decode of the bus as presented in the setup phase.
   always_comb begin
      off    = apb_addr_i - BASE_ADDR;
      idx_in = off[IDX_W+1:2];
      err_in = (apb_addr_i < BASE_ADDR) || (off[1:0] != 2'b00)
            || (off[APB_ADDR_W-1:2] >= 30'(NUM_REGS))
            || (apb_write_i && (off[APB_ADDR_W-1:2] == '0))
            || ((PRIV_WRITE != 0) && apb_write_i && !apb_prot_i[0]);
   end

   // With zero wait states DONE is entered straight from the setup edge, so the
   // live decode is used there instead of the latched copy.
   assign cur_idx   = (state_q == ST_IDLE) ? idx_in      : idx_q;
   assign cur_err   = (state_q == ST_IDLE) ? err_in      : err_q;
   assign cur_write = (state_q == ST_IDLE) ? apb_write_i : write_q;

   always_comb begin
      rd_val = '0;
      if (cur_idx == '0) rd_val = id_i;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (cur_idx == IDX_W'(i)) rd_val = regs_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = 1'b0;
      slverr_d   = 1'b0;
      rdata_d    = '0;
      latch      = 1'b0;
      commit     = 1'b0;
      enter_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (apb_sel_i && !apb_enable_i) begin
               latch = 1'b1;
               cnt_d = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) enter_done = 1'b1;
               else                  state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!apb_sel_i) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) enter_done = 1'b1;
            end
         end
         ST_DONE: begin
            if (!apb_sel_i) begin
               state_d = ST_IDLE;
            end else if (apb_enable_i) begin
               commit  = write_q && !err_q;
               state_d = ST_IDLE;
            end else begin
               ready_d  = 1'b1;
               slverr_d = slverr_q;
               rdata_d  = rdata_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (enter_done) begin
         state_d  = ST_DONE;
         ready_d  = 1'b1;
         slverr_d = cur_err;
         rdata_d  = (!cur_write && !cur_err) ? rd_val : '0;
      end
   end

   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
         rdata_q  <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         strb_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         slverr_q <= slverr_d;
         rdata_q  <= rdata_d;
         if (latch) begin
            idx_q   <= idx_in;
            write_q <= apb_write_i;
            err_q   <= err_in;
            strb_q  <= apb_strb_i;
            wdata_q <= apb_wdata_i;
         end
      end
   end

   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= '0;
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (commit && (idx_q == IDX_W'(i))) begin
               regs_q[i]     <= merged[i];
               wr_pulse_q[i] <= 1'b1;
            end
         end
      end
   end

   assign regs_o[APB_DATA_W-1:0] = id_i;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      apb_strb_merge u_merge (
         .old_data (regs_q[g]),
         .new_data (wdata_q),
         .strb     (strb_q),
         .merged   (merged[g])
      );
      assign regs_o[APB_DATA_W*g +: APB_DATA_W] = regs_q[g];
   end

   assign apb_ready_o  = ready_q;
   assign apb_slverr_o = slverr_q;
   assign apb_rdata_o  = rdata_q;
   assign wr_pulse_o   = wr_pulse_q;

endmodule

// File: tb/tb_apb_regfile_responder.sv
// Bench for apb_regfile_responder: three instances (zero-wait, 3-wait, privileged/offset base)
// driven from a vector table, with a scoreboard queue of expected completions.
module tb_apb_regfile_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, id;
   logic [2:0]  sel;
   logic        enable, write;
   logic [3:0]  strb;
   logic [2:0]  prot;

   logic [2:0]        rdy, slv;
   logic [2:0][31:0]  rd;
   logic [2:0][7:0]   pulse;
   logic [2:0][255:0] regs;

   always #5 clk = ~clk;

   apb_regfile_responder #(
      .BASE_ADDR(32'h0000_0000), .NUM_REGS(8), .WAIT_CYCLES(0),
      .RESET_VALUE(32'h0000_0000), .PRIV_WRITE(0)
   ) dut0 (
      .apb_clk_i(clk), .apb_reset_i(rst), .apb_addr_i(addr), .apb_sel_i(sel[0]),
      .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb), .apb_prot_i(prot),
      .apb_wdata_i(wdata), .apb_ready_o(rdy[0]), .apb_rdata_o(rd[0]), .apb_slverr_o(slv[0]),
      .id_i(id), .regs_o(regs[0]), .wr_pulse_o(pulse[0])
   );

   apb_regfile_responder #(
      .BASE_ADDR(32'h0000_0000), .NUM_REGS(8), .WAIT_CYCLES(3),
      .RESET_VALUE(32'h5A5A_0000), .PRIV_WRITE(0)
   ) dut1 (
      .apb_clk_i(clk), .apb_reset_i(rst), .apb_addr_i(addr), .apb_sel_i(sel[1]),
      .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb), .apb_prot_i(prot),
      .apb_wdata_i(wdata), .apb_ready_o(rdy[1]), .apb_rdata_o(rd[1]), .apb_slverr_o(slv[1]),
      .id_i(id), .regs_o(regs[1]), .wr_pulse_o(pulse[1])
   );

   apb_regfile_responder #(
      .BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_CYCLES(1),
      .RESET_VALUE(32'h0000_0000), .PRIV_WRITE(1)
   ) dut2 (
      .apb_clk_i(clk), .apb_reset_i(rst), .apb_addr_i(addr), .apb_sel_i(sel[2]),
      .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb), .apb_prot_i(prot),
      .apb_wdata_i(wdata), .apb_ready_o(rdy[2]), .apb_rdata_o(rd[2]), .apb_slverr_o(slv[2]),
      .id_i(id), .regs_o(regs[2]), .wr_pulse_o(pulse[2])
   );

   typedef struct {
      int          k;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   typedef struct {
      int          k;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [2:0]  p;
      logic [31:0] er;
      bit          ee;
      logic [7:0]  ep;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   wc[3] = '{0, 3, 1};
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [2:0] p, input logic [31:0] er,
                               input bit ee, input logic [7:0] ep);
      vec_t v;
      v.k = k; v.wr = wr; v.a = a; v.d = d; v.s = s; v.p = p; v.er = er; v.ee = ee; v.ep = ep;
      return v;
   endfunction

   task automatic bus_idle();
      sel = '0; enable = 1'b0; write = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the completion edge
   // with the bus idle, so consecutive calls give back-to-back transfers.
   task automatic xfer(input vec_t v, input string nm);
      exp_t e, got;
      int   waits;
      e.k = v.k; e.rdata = v.er; e.err = v.ee; e.waits = wc[v.k];
      sb.push_back(e);
      addr = v.a; wdata = v.d; strb = v.s; prot = v.p; write = v.wr;
      sel = '0; sel[v.k] = 1'b1; enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      waits  = 0;
      while (rdy[v.k] !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      got = sb.pop_front();
      check({nm, " ready"}, {31'b0, rdy[got.k]}, 32'd1);
      check({nm, " wait_cycles"}, 32'(waits), 32'(got.waits));
      check({nm, " rdata"}, rd[got.k], got.rdata);
      check({nm, " slverr"}, {31'b0, slv[got.k]}, {31'b0, got.err});
      @(negedge clk);
      check({nm, " wr_pulse"}, {24'b0, pulse[v.k]}, {24'b0, v.ep});
      bus_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      id = 32'hC0DE_0001;
      addr = '0; wdata = '0; strb = '0; prot = '0;
      bus_idle();

      //            k  wr addr          wdata         strb    prot    exp_rdata     err pulse
      vecs.push_back(mk(0, 1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0,         0, 8'h02));
      vecs.push_back(mk(0, 0, 32'h0000_0004, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 0, 8'h00));
      vecs.push_back(mk(0, 1, 32'h0000_0008, 32'h1122_3344, 4'hF, 3'b000, 32'h0,         0, 8'h04));
      vecs.push_back(mk(0, 1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 3'b000, 32'h0,         0, 8'h04));
      vecs.push_back(mk(0, 0, 32'h0000_0008, 32'h0,         4'h0, 3'b000, 32'h11BB_33DD, 0, 8'h00));
      vecs.push_back(mk(0, 1, 32'h0000_000C, 32'h1234_5678, 4'h0, 3'b000, 32'h0,         0, 8'h08));
      vecs.push_back(mk(0, 0, 32'h0000_000C, 32'h0,         4'h0, 3'b000, 32'h0,         0, 8'h00));
      vecs.push_back(mk(0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0,         1, 8'h00));
      vecs.push_back(mk(0, 0, 32'h0000_0000, 32'h0,         4'h0, 3'b000, 32'hC0DE_0001, 0, 8'h00));
      vecs.push_back(mk(0, 0, 32'h0000_0020, 32'h0,         4'h0, 3'b000, 32'h0,         1, 8'h00));
      vecs.push_back(mk(0, 0, 32'h0000_0006, 32'h0,         4'h0, 3'b000, 32'h0,         1, 8'h00));
      vecs.push_back(mk(0, 1, 32'h0000_001C, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0,         0, 8'h80));
      vecs.push_back(mk(0, 0, 32'h0000_001C, 32'h0,         4'h0, 3'b000, 32'hCAFE_F00D, 0, 8'h00));
      vecs.push_back(mk(1, 0, 32'h0000_0004, 32'h0,         4'h0, 3'b000, 32'h5A5A_0000, 0, 8'h00));
      vecs.push_back(mk(1, 1, 32'h0000_0010, 32'h0102_0304, 4'hF, 3'b000, 32'h0,         0, 8'h10));
      vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,         4'h0, 3'b000, 32'h0102_0304, 0, 8'h00));
      vecs.push_back(mk(2, 1, 32'h0000_1004, 32'h1111_1111, 4'hF, 3'b000, 32'h0,         1, 8'h00));
      vecs.push_back(mk(2, 0, 32'h0000_1004, 32'h0,         4'h0, 3'b000, 32'h0,         0, 8'h00));
      vecs.push_back(mk(2, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b001, 32'h0,         0, 8'h02));
      vecs.push_back(mk(2, 0, 32'h0000_1004, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 0, 8'h00));
      vecs.push_back(mk(2, 0, 32'h0000_0FFC, 32'h0,         4'h0, 3'b000, 32'h0,         1, 8'h00));

      // Reset held for three cycles.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset ready%0d", k), {31'b0, rdy[k]}, 32'd0);
         check($sformatf("reset slverr%0d", k), {31'b0, slv[k]}, 32'd0);
         check($sformatf("reset rdata%0d", k), rd[k], 32'd0);
         check($sformatf("reset pulse%0d", k), {24'b0, pulse[k]}, 32'd0);
         check($sformatf("reset reg1_%0d", k), regs[k][63:32], (k == 1) ? 32'h5A5A_0000 : 32'h0);
         check($sformatf("reset reg0_%0d", k), regs[k][31:0], 32'hC0DE_0001);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) xfer(vecs[i], $sformatf("vec%0d", i));

      // Write pulse lasts a single cycle.
      xfer(mk(0, 1, 32'h14, 32'h0000_0055, 4'hF, 3'b000, 32'h0, 0, 8'h20), "pulse_write");
      @(negedge clk);
      check("pulse_one_cycle", {24'b0, pulse[0]}, 32'd0);

      // PENABLE high in IDLE without a setup phase is ignored.
      addr = 32'h4; wdata = 32'hFFFF_FFFF; strb = 4'hF; write = 1'b1;
      sel = 3'b001; enable = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_enable ready", {31'b0, rdy[0]}, 32'd0);
      check("idle_enable pulse", {24'b0, pulse[0]}, 32'd0);
      bus_idle();
      @(negedge clk);

      // PSEL dropped during the wait phase aborts without a write.
      addr = 32'h14; wdata = 32'hBAD0_BAD0; strb = 4'hF; prot = '0; write = 1'b1;
      sel = 3'b010; enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      bus_idle();
      repeat (5) @(negedge clk);
      check("abort ready", {31'b0, rdy[1]}, 32'd0);
      check("abort pulse", {24'b0, pulse[1]}, 32'd0);
      check("abort reg5", regs[1][191:160], 32'h5A5A_0000);
      xfer(mk(1, 0, 32'h14, 32'h0, 4'h0, 3'b000, 32'h5A5A_0000, 0, 8'h00), "after_abort");

      // Register contents after the error and ignored-enable cases.
      check("final dut0 reg1", regs[0][63:32], 32'hDEAD_BEEF);
      check("final dut0 reg2", regs[0][95:64], 32'h11BB_33DD);
      check("final dut0 reg3", regs[0][127:96], 32'h0);
      check("final dut0 reg5", regs[0][191:160], 32'h0000_0055);
      check("final dut0 reg7", regs[0][255:224], 32'hCAFE_F00D);
      check("final dut2 reg1", regs[2][63:32], 32'hDEAD_BEEF);

      // Reset in the middle of an access phase.
      addr = 32'h18; wdata = 32'h0000_0077; strb = 4'hF; write = 1'b1;
      sel = 3'b010; enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      bus_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset ready", {31'b0, rdy[1]}, 32'd0);
      check("midreset reg6", regs[1][223:192], 32'h5A5A_0000);
      check("midreset pulse", {24'b0, pulse[1]}, 32'd0);
      xfer(mk(1, 0, 32'h18, 32'h0, 4'h0, 3'b000, 32'h5A5A_0000, 0, 8'h00), "after_reset_rd");
      xfer(mk(1, 1, 32'h18, 32'h0000_0099, 4'h3, 3'b000, 32'h0, 0, 8'h40), "after_reset_wr");
      xfer(mk(1, 0, 32'h18, 32'h0, 4'h0, 3'b000, 32'h5A5A_0099, 0, 8'h00), "after_reset_rb");
      xfer(mk(0, 0, 32'h4, 32'h0, 4'h0, 3'b000, 32'h0, 0, 8'h00), "dut0_after_reset");

      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
